// File: rtl/axil_latency_mem.sv
// AXI4-Lite slave word memory with programmable read/write latency, a read-address FIFO
// and DECERR responses for accesses outside [BASE, BASE + DEPTH*DATA_W/8).
module axil_latency_mem #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
   parameter int unsigned       DEPTH    = 1024,
   parameter int unsigned       RD_LAT   = 1,
   parameter int unsigned       WR_LAT   = 0,
   parameter int unsigned       RQ_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [2:0]          awprot,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [2:0]          arprot,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned PTR_W  = $clog2(RQ_DEPTH);
   localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(DEPTH * STRB_W);
   localparam logic [PTR_W:0]  RQ_FULL  = (PTR_W+1)'(RQ_DEPTH);
   localparam logic [3:0]      RD_LAT_C = 4'(RD_LAT);
   localparam logic [3:0]      WR_LAT_C = 4'(WR_LAT);
   localparam logic [1:0]      OKAY     = 2'b00;
   localparam logic [1:0]      DECERR   = 2'b11;

   typedef enum logic [1:0] {RIdle, RWait, RResp} rstate_e;
   typedef enum logic [1:0] {WIdle, WWait, WResp} wstate_e;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= BASE) && ({1'b0, a - BASE} < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE) >> OFF_W);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   // Read-address FIFO
   logic [ADDR_W-1:0] rq_mem [RQ_DEPTH];
   logic [PTR_W-1:0]  rq_wptr_q, rq_rptr_q;
   logic [PTR_W:0]    rq_cnt_q;
   logic              rq_empty, rq_push, rq_pop;

   rstate_e           rstate_q, rstate_d;
   logic [3:0]        rcnt_q, rcnt_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   wstate_e           wstate_q, wstate_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              aw_hs, w_hs, wr_commit;
   logic [IDX_W-1:0]  rd_idx, wr_idx;

   assign arready  = !rst && (rq_cnt_q != RQ_FULL);
   assign awready  = !rst && !aw_held_q;
   assign wready   = !rst && !w_held_q;
   assign rq_empty = (rq_cnt_q == '0);
   assign rq_push  = arvalid && arready;
   assign rq_pop   = (rstate_q == RIdle) && !rq_empty;
   assign aw_hs    = awvalid && awready;
   assign w_hs     = wvalid && wready;
   assign rd_idx   = word_idx(raddr_q);
   assign wr_idx   = word_idx(aw_addr_q);

   always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = rcnt_q;
      raddr_d  = raddr_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         RIdle: begin
            if (!rq_empty) begin
               raddr_d  = rq_mem[rq_rptr_q];
               rcnt_d   = RD_LAT_C;
               rstate_d = RWait;
            end
         end
         RWait: begin
            if (rcnt_q == '0) begin
               rvalid_d = 1'b1;
               rstate_d = RResp;
               if (in_range(raddr_q)) begin
                  rdata_d = mem[rd_idx];
                  rresp_d = OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = DECERR;
               end
            end else begin
               rcnt_d = rcnt_q - 4'd1;
            end
         end
         RResp: begin
            if (rready) begin
               rvalid_d = 1'b0;
               rstate_d = RIdle;
            end
         end
         default: rstate_d = RIdle;
      endcase
   end

   always_comb begin
      wstate_d  = wstate_q;
      wcnt_d    = wcnt_q;
      aw_held_d = aw_held_q || aw_hs;
      w_held_d  = w_held_q || w_hs;
      aw_addr_d = aw_hs ? awaddr : aw_addr_q;
      w_data_d  = w_hs ? wdata : w_data_q;
      w_strb_d  = w_hs ? wstrb : w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wr_commit = 1'b0;
      case (wstate_q)
         WIdle: begin
            // Leave idle on the edge that completes the AW/W pair, so WR_LAT counts from pairing.
            if (aw_held_d && w_held_d) begin
               wcnt_d   = WR_LAT_C;
               wstate_d = WWait;
            end
         end
         WWait: begin
            if (wcnt_q == '0) begin
               wr_commit = in_range(aw_addr_q);
               bresp_d   = in_range(aw_addr_q) ? OKAY : DECERR;
               bvalid_d  = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               wstate_d  = WResp;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         WResp: begin
            if (bready) begin
               bvalid_d = 1'b0;
               wstate_d = WIdle;
            end
         end
         default: wstate_d = WIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rq_wptr_q <= '0;
         rq_rptr_q <= '0;
         rq_cnt_q  <= '0;
         rstate_q  <= RIdle;
         rcnt_q    <= '0;
         raddr_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         wstate_q  <= WIdle;
         wcnt_q    <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         if (rq_push) rq_wptr_q <= rq_wptr_q + 1'b1;
         if (rq_pop)  rq_rptr_q <= rq_rptr_q + 1'b1;
         if (rq_push && !rq_pop)      rq_cnt_q <= rq_cnt_q + 1'b1;
         else if (!rq_push && rq_pop) rq_cnt_q <= rq_cnt_q - 1'b1;
         rstate_q  <= rstate_d;
         rcnt_q    <= rcnt_d;
         raddr_q   <= raddr_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         wstate_q  <= wstate_d;
         wcnt_q    <= wcnt_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Storage is never reset; a commit pending at reset is dropped.
   always_ff @(posedge clk) begin
      if (rq_push) rq_mem[rq_wptr_q] <= araddr;
      if (!rst && wr_commit) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) mem[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
         end
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign bvalid = bvalid_q;
   assign bresp  = bresp_q;

   logic unused_prot;
   assign unused_prot = ^{awprot, arprot};

endmodule

// File: tb/tb_axil_latency_mem.sv
// Directed bench for axil_latency_mem: a word-level memory model plus expected-response
// queues, checked every cycle a response handshakes, plus literal spot checks.
module tb_axil_latency_mem;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid, bready = 1'b1;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = '0;
   logic        rvalid, rready = 1'b1;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   axil_latency_mem #(
      .ADDR_W(32), .DATA_W(32), .BASE(BASE), .DEPTH(DEPTH),
      .RD_LAT(1), .WR_LAT(2), .RQ_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic [31:0] model_mem [DEPTH];
   rexp_t       exp_r [$];
   logic [1:0]  exp_b [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
   endtask

   function automatic bit m_in_range(input logic [31:0] a);
      return (a >= BASE) && (a - BASE < 32'(DEPTH * 4));
   endfunction

   function automatic rexp_t m_read(input logic [31:0] a);
      rexp_t e;
      if (m_in_range(a)) e = '{data: model_mem[(a - BASE) >> 2], resp: 2'b00};
      else               e = '{data: 32'h0, resp: 2'b11};
      return e;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m_in_range(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[(a - BASE) >> 2][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   // Every response handshake is compared against the model's queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (rvalid && rready) begin
            if (exp_r.size() == 0) fail("r_unexpected");
            else begin
               check("rdata", rdata, exp_r[0].data);
               check("rresp", rresp, exp_r[0].resp);
               void'(exp_r.pop_front());
            end
         end
         if (bvalid && bready) begin
            if (exp_b.size() == 0) fail("b_unexpected");
            else check("bresp", bresp, exp_b.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit expect_commit, output int hs_cyc);
      bit aw_hs, w_hs;
      int g = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while ((awvalid || wvalid) && g < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         g++;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid = 1'b0;
      end
      if (awvalid || wvalid) fail("aw_w_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
      hs_cyc = cyc;
      if (expect_commit) begin
         exp_b.push_back(m_in_range(a) ? 2'b00 : 2'b11);
         m_write(a, d, s);
      end
   endtask

   task automatic wait_b(output int rise_cyc, output logic [1:0] resp);
      int g = 0;
      while (!bvalid && g < 50) begin tick(); g++; end
      if (!bvalid) fail("bvalid_timeout");
      rise_cyc = cyc;
      resp = bresp;
      if (bready) tick();
   endtask

   task automatic do_read(input logic [31:0] a, output int hs_cyc);
      bit hs = 1'b0;
      int g = 0;
      araddr = a; arvalid = 1'b1;
      while (!hs && g < 50) begin
         hs = arready;
         tick();
         g++;
      end
      if (!hs) fail("ar_handshake");
      arvalid = 1'b0;
      hs_cyc = cyc;
      exp_r.push_back(m_read(a));
   endtask

   task automatic wait_r(output int rise_cyc, output logic [31:0] d, output logic [1:0] r);
      int g = 0;
      while (!rvalid && g < 50) begin tick(); g++; end
      if (!rvalid) fail("rvalid_timeout");
      rise_cyc = cyc;
      d = rdata;
      r = rresp;
      if (rready) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected bench completion");
      $fatal(1);
   end

   initial begin
      int          hc, rc, g, accepted;
      logic [31:0] d;
      logic [1:0]  r;
      logic [31:0] t3_addr [5];
      bit          hs;

      // Reset state
      tick(); tick(); tick();
      check("rst_arready", arready, 0);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_resps", {rresp, bresp}, 0);
      rst = 1'b0;
      tick();
      check("idle_readies", {arready, awready, wready}, 3'b111);

      // 1: full word write then read, latency 2+RD_LAT
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, hc);
      wait_b(rc, r);
      check("t1_bresp", r, 2'b00);
      do_read(32'h8000_0010, hc);
      wait_r(rc, d, r);
      check("t1_latency", rc - hc, 3);
      check("t1_rdata", d, 32'hDEAD_BEEF);
      check("t1_rresp", r, 2'b00);

      // 2: byte strobes
      do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 1'b1, hc);
      wait_b(rc, r);
      do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1, hc);
      wait_b(rc, r);
      do_read(32'h8000_0020, hc);
      wait_r(rc, d, r);
      check("t2_rdata", d, 32'h11BB_33DD);

      // Preload words used later
      do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 1'b1, hc); wait_b(rc, r);
      do_write(32'h8000_0030, 32'h3333_3333, 4'hF, 1'b1, hc); wait_b(rc, r);
      do_write(32'h8000_0040, 32'h4444_4444, 4'hF, 1'b1, hc); wait_b(rc, r);

      // 3: FIFO fills with rready low, then drains in order
      t3_addr = '{32'h8000_0010, 32'h8000_0020, 32'h8000_0030, 32'h8000_0040, 32'h8000_0000};
      rready = 1'b0;
      arvalid = 1'b1;
      accepted = 0;
      g = 0;
      while (accepted < 5 && g < 50) begin
         araddr = t3_addr[accepted];
         hs = arready;
         tick();
         g++;
         if (hs) begin
            exp_r.push_back(m_read(t3_addr[accepted]));
            accepted++;
         end
      end
      arvalid = 1'b0;
      check("t3_accepts", accepted, 5);
      tick(); tick(); tick();
      check("t3_arready_full", arready, 0);
      check("t3_rvalid_held", rvalid, 1);
      rready = 1'b1;
      g = 0;
      while (exp_r.size() != 0 && g < 100) begin tick(); g++; end
      check("t3_drained", exp_r.size(), 0);
      tick();
      check("t3_arready_back", arready, 1);

      // 4: W three cycles before AW, WR_LAT=2
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
      g = 0;
      hs = 1'b0;
      while (!hs && g < 50) begin hs = wready; tick(); g++; end
      if (!hs) fail("t4_w_handshake");
      wvalid = 1'b0;
      tick(); tick(); tick();
      check("t4_no_early_b", bvalid, 0);
      awaddr = 32'h8000_0050; awvalid = 1'b1;
      g = 0;
      hs = 1'b0;
      while (!hs && g < 50) begin hs = awready; tick(); g++; end
      if (!hs) fail("t4_aw_handshake");
      awvalid = 1'b0;
      hc = cyc;
      exp_b.push_back(2'b00);
      m_write(32'h8000_0050, 32'hCAFE_F00D, 4'hF);
      wait_b(rc, r);
      check("t4_b_latency", rc - hc, 3);
      do_read(32'h8000_0050, hc);
      wait_r(rc, d, r);
      check("t4_rdata", d, 32'hCAFE_F00D);

      // 5: out-of-range read and write
      do_read(32'h7FFF_FFFC, hc);
      wait_r(rc, d, r);
      check("t5_rdata", d, 32'h0);
      check("t5_rresp", r, 2'b11);
      do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, hc);
      wait_b(rc, r);
      check("t5_bresp", r, 2'b11);
      do_read(32'h8000_0000, hc);
      wait_r(rc, d, r);
      check("t5_word0", d, 32'h0BAD_F00D);

      // 6: reset with rvalid high and a write in its latency wait
      rready = 1'b0;
      do_read(32'h8000_0030, hc);
      wait_r(rc, d, r);
      do_write(32'h8000_0030, 32'h6666_6666, 4'hF, 1'b0, hc);
      rst = 1'b1;
      tick();
      check("t6_rvalid", rvalid, 0);
      check("t6_bvalid", bvalid, 0);
      check("t6_readies", {arready, awready, wready}, 3'b000);
      rst = 1'b0;
      exp_r.delete();
      exp_b.delete();
      rready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("t6_no_late_b", bvalid, 0);
      do_read(32'h8000_0030, hc);
      wait_r(rc, d, r);
      check("t6_word_kept", d, 32'h3333_3333);

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axil_latency_mem.md
Name: axil_latency_mem

Overview:
Parametrised AXI4-Lite slave memory with an internal word array, programmable read/write latency, a multi-entry read-address queue and error responses for out-of-range accesses. It replaces the zero-latency, DPI-backed simulation memory on the core's memory port. It lets the NPC bus be exercised under realistic slave timing with a synthesizable model. Out-of-range accesses return DECERR instead of stopping simulation.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; must be 32 or 64.
BASE, 32'h8000_0000, byte address of word 0.
DEPTH, 1024, number of DATA_W words; power of two.
RD_LAT, 1, extra wait cycles between dequeuing a read and asserting rvalid; range 0..15.
WR_LAT, 0, extra wait cycles between holding both AW and W and committing the write; range 0..15.
RQ_DEPTH, 4, read-address FIFO entries; power of two, at least 2.

Ports:
clk  in  1  single clock, rising-edge.
rst  in  1  synchronous active-high reset.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  ADDR_W  write byte address.
awprot  in  3  ignored.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DATA_W  write data.
wstrb  in  DATA_W/8  byte enables.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
bresp  out  2  write response: 00 OKAY, 11 DECERR.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  ADDR_W  read byte address.
arprot  in  3  ignored.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  DATA_W  read data.
rresp  out  2  read response: 00 OKAY, 11 DECERR.

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - Clears the read FIFO, both holding registers, both FSMs and all counters.
  - Outputs: bvalid=0, rvalid=0, rdata=0, rresp=00, bresp=00.
  - arready, awready and wready are forced 0 while rst=1.
  - Array contents are not reset.
  - Transactions in flight are dropped; a write not yet committed is never committed.
- Address decode:
  - In range iff BASE <= addr < BASE + DEPTH*(DATA_W/8).
  - Word index = (addr-BASE) >> log2(DATA_W/8).
  - Low byte-offset bits are ignored, so unaligned addresses access the containing word.
- Read path:
  - arready = !rst && FIFO not full. There is no bypass: arready stays low when the FIFO is full, even if it pops in the same cycle.
  - FSM states R_IDLE, R_WAIT, R_RESP.
  - R_IDLE with FIFO non-empty: pop the head, load the counter with RD_LAT, go to R_WAIT.
  - R_WAIT decrements the counter each cycle. When the counter is 0, sample the array (or 0 plus DECERR if out of range) into rdata/rresp, set rvalid, go to R_RESP.
  - R_RESP holds rvalid, rdata and rresp stable until rready. On the rvalid&&rready edge, clear rvalid and go to R_IDLE.
  - Minimum latency: an AR handshake at edge N into an empty FIFO with the FSM idle gives rvalid high after edge N+2+RD_LAT.
  - Responses are returned strictly in AR order.
- Write path:
  - Separate one-entry AW and W holding registers. awready = !rst && !aw_held; wready = !rst && !w_held.
  - AW and W may arrive in either order or in the same cycle.
  - FSM states W_IDLE, W_WAIT, W_RESP.
  - W_IDLE with both registers held and bvalid=0: load the counter with WR_LAT, go to W_WAIT.
  - W_WAIT at counter 0:
    - If in range, commit the write, updating only the bytes whose wstrb bit is set.
    - Set bresp = OKAY if in range, DECERR otherwise (array untouched).
    - Set bvalid, clear both holding registers, go to W_RESP.
  - W_RESP: clear bvalid on bvalid&&bready, go to W_IDLE.
  - New AW/W may be captured while in W_RESP.
  - wstrb=0 is a legal no-op write with response OKAY.
- Read/write collision: a write committing on the same edge that rdata samples the same word is not visible; the read returns the pre-write data.
- Read and write paths run fully concurrently and independently.

Test Plan:
1. Write 0xDEADBEEF to 0x8000_0010 with wstrb=1111, then read 0x8000_0010 (RD_LAT=1) -> bresp=00; rdata=0xDEADBEEF; rresp=00; rvalid rises exactly 3 edges after the AR handshake.
2. Byte strobes: write 0x11223344 to 0x8000_0020 (wstrb=1111), then 0xAABBCCDD with wstrb=0101, then read -> rdata=0x11BB33DD.
3. Back-to-back reads of 5 addresses with rready=0 and RQ_DEPTH=4 -> arready drops after 4 accepts plus 1 in service. Releasing rready returns all 5 in order with correct data.
4. W presented 3 cycles before AW, WR_LAT=2 -> the write commits and bvalid rises 3 edges after the AW handshake. A read issued afterwards sees the new data.
5. Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024, DATA_W=32) -> rresp=11 with rdata=0, and bresp=11. The array is unchanged, verified by a read of 0x8000_0000.
6. Assert rst while rvalid=1 and a write is in W_WAIT -> rvalid=0 and bvalid=0 on the next edge, and the target word keeps its old value.
